somador_subtrator_seq: RTL and testbench

Parametrised, multi-cycle adder/subtractor, the WIDTH-bit generalisation of the 4-bit ripple add/sub unit used in the ALU datapath. It accepts one operation through a valid/ready handshake and processes CHUNK bits per clock through a single shared CHUNK-bit ripple slice, carrying between slices in a register. It returns the WIDTH-bit result with carry, overflow, zero and negative flags through a second valid/ready handshake. It sits between the ALU operand registers and the result/flag write-back stage.

---
 rtl/somador_pkg.sv | 19 +
 rtl/somador_chunk.sv | 28 ++
 rtl/somador_subtrator_seq.sv | 126 ++++++++++++
 tb/tb_somador_subtrator_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// Shared types and sizing helpers for the sequential adder/subtractor.
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/somador_chunk.sv
// Combinational CHUNK-bit ripple of full adders, time-multiplexed by the top.
module somador_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/somador_subtrator_seq.sv
// Multi-cycle WIDTH-bit add/sub: one CHUNK-bit slice per clock, carry held in a register.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready/valid depend on state only.
module somador_subtrator_seq
    import somador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             modo_sub,
    input  logic             cin_inicial,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ov,
    output logic             zero,
    output logic             neg,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(NCHUNK);

    if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_param_err
        $error("somador_subtrator_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, s_q, s_full;
    logic              cout_q, ov_q, zero_q, neg_q;
    logic [CHUNK-1:0]  a_slice, b_slice, slice_sum;
    logic              slice_cout, slice_cmsb;
    logic              last;

    assign last = (idx == IDXW'(NCHUNK - 1));

    always_comb begin
        a_slice = a_q[int'(idx) * CHUNK +: CHUNK];
        b_slice = b_q[int'(idx) * CHUNK +: CHUNK];
    end

    somador_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x     (a_slice),
        .y     (b_slice),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // Result with the current chunk merged in, so flags see the completed word on the last edge.
    always_comb begin
        s_full = s_q;
        s_full[int'(idx) * CHUNK +: CHUNK] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{modo_sub}};
                        carry_q <= cin_inicial;
                        idx     <= '0;
                    end
                end
                CALC: begin
                    s_q     <= s_full;
                    carry_q <= slice_cout;
                    idx     <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout_q <= slice_cout;
                        ov_q   <= slice_cout ^ slice_cmsb;
                        zero_q <= (s_full == '0);
                        neg_q  <= s_full[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ov        = ov_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_somador_subtrator_seq.sv
// Directed and random checks of the sequential adder/subtractor against a plain-arithmetic model.
module tb_somador_subtrator_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        modo_sub = 1'b0, cin = 1'b0;

    logic        iv0, iv1, or0, or1;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [15:0] s0, s1;
    logic        cout0, cout1, ov0, ov1, zero0, zero1, neg0, neg1;
    logic [1:0]  dbg0, dbg1;

    logic        in_ready, out_valid, cout, ov, zero, neg;
    logic [15:0] s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign iv0 = in_valid && !sel;
    assign iv1 = in_valid && sel;
    assign or0 = out_ready && !sel;
    assign or1 = out_ready && sel;

    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign s         = sel ? s1    : s0;
    assign cout      = sel ? cout1 : cout0;
    assign ov        = sel ? ov1   : ov0;
    assign zero      = sel ? zero1 : zero0;
    assign neg       = sel ? neg1  : neg0;

    somador_subtrator_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0),
        .a(a), .b(b), .modo_sub(modo_sub), .cin_inicial(cin),
        .out_valid(out_valid0), .out_ready(or0), .s(s0),
        .cout(cout0), .ov(ov0), .zero(zero0), .neg(neg0), .dbg_state(dbg0)
    );

    somador_subtrator_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1),
        .a(a), .b(b), .modo_sub(modo_sub), .cin_inicial(cin),
        .out_valid(out_valid1), .out_ready(or1), .s(s1),
        .cout(cout1), .ov(ov1), .zero(zero1), .neg(neg1), .dbg_state(dbg1)
    );

    // Returns {cout, ov, s} from whole-word arithmetic.
    function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic m, input logic c);
        logic [15:0] ym;
        logic [16:0] full;
        logic        v;
        ym   = m ? ~y : y;
        full = 17'(x) + 17'(ym) + 17'(c);
        v    = (x[15] == ym[15]) && (full[15] != x[15]);
        return {full[16], v, full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input logic [17:0] e);
        check("s",    32'(s),    32'(e[15:0]));
        check("cout", 32'(cout), 32'(e[17]));
        check("ov",   32'(ov),   32'(e[16]));
        check("zero", 32'(zero), 32'(e[15:0] == 16'h0));
        check("neg",  32'(neg),  32'(e[15]));
    endtask

    // Accept one op, measure latency, check result, then release after `hold` extra cycles.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                          input logic tc, input int exp_lat, input int hold);
        logic [17:0] e;
        int lat;
        e = ref_model(ta, tb_, tm, tc);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_; modo_sub = tm; cin = tc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check_result(e);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_s", 32'(s), 32'(e[15:0]));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("released_valid", 32'(out_valid), 32'd0);
        check("released_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [17:0] e;
        int lat;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s",    32'(s),    32'd0);
        check("rst_flags", 32'({cout, ov, zero, neg}), 32'd0);

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 4, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 4, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 4, 1);

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
        e = ref_model(16'h1234, 16'h4321, 1'b0, 1'b1);
        a = 16'h1234; b = 16'h4321; modo_sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 16'($urandom); b = 16'($urandom);
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_result(e);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset two cycles into CALC aborts the operation.
        a = 16'hAAAA; b = 16'h5555; modo_sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_s",     32'(s),         32'd0);
        check("mid_rst_flags", 32'({cout, ov, zero, neg}), 32'd0);
        step();
        check("mid_rst_still_idle", 32'(out_valid), 32'd0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 4, 0);
        check("after_rst_sum", 32'(s), 32'h2345);

        // Single-chunk build.
        sel = 1'b1;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1, 0);
        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        sel = 1'b0;

        for (int i = 0; i < 1000; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4,
                   int'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
